conv_wr_arbiter: RTL

- Shares the single result-memory write port (cwr/caddr_wr/cdata_wr/csel) of the CONV top among several producers: layer-0 convolution writer, max-pool writer, flatten writer.
- Each requester has a small skid FIFO; a round-robin arbiter drains them at one write per cycle.
- Tracks per-requester "last" markers and signals run completion, so CONV busy can be driven from one place.

---
 rtl/conv_arb_pkg.sv | 18 +
 rtl/conv_arb_fifo.sv | 47 ++++
 rtl/conv_wr_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/conv_arb_pkg.sv
// Shared types and constants for the CONV result-memory write arbiter.
package conv_arb_pkg;

    localparam int CONV_ADDR_W = 12;
    localparam int CONV_DATA_W = 20;
    localparam int CONV_SEL_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    localparam logic [2:0] SEL_L0 = 3'b001;
    localparam logic [2:0] SEL_L1 = 3'b011;
    localparam logic [2:0] SEL_L2 = 3'b101;

endpackage

// File: rtl/conv_arb_fifo.sv
// Small per-requester skid FIFO holding packed {last, sel, addr, data} entries.
module conv_arb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 36
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: storage is deliberately not reset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/conv_wr_arbiter.sv
// Round-robin arbiter sharing the CONV result-memory write port among N_REQ producers.
// Optional per-requester write counters are enabled with `define CONV_ARB_STAT_EN.
module conv_wr_arbiter
    import conv_arb_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int ADDR_W     = CONV_ADDR_W,
    parameter int DATA_W     = CONV_DATA_W,
    parameter int SEL_W      = CONV_SEL_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ*SEL_W-1:0]    req_sel,
    input  logic [N_REQ-1:0]          req_last,
    output logic                      cwr,
    output logic [ADDR_W-1:0]         caddr_wr,
    output logic [DATA_W-1:0]         cdata_wr,
    output logic [SEL_W-1:0]          csel,
    output logic                      busy,
    output logic                      done
`ifdef CONV_ARB_STAT_EN
    ,
    output logic [N_REQ*(ADDR_W+1)-1:0] wr_cnt
`endif
);

    localparam int ENT_W = 1 + SEL_W + ADDR_W + DATA_W;
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);

    arb_state_t        state, state_nxt;
    logic              run, start_acc;
    logic [IDX_W-1:0]  rr_ptr, grant_idx;
    logic              grant_valid;
    logic [N_REQ-1:0]  fifo_empty, push, pop, last_flag;
    logic [ENT_W-1:0]  fifo_dout [N_REQ];
    logic [CNT_W-1:0]  fifo_count [N_REQ];
    logic [ENT_W-1:0]  head;

    for (genvar i = 0; i < N_REQ; i++) begin : g_req
        assign req_ready[i] = run && (fifo_count[i] < CNT_W'(FIFO_DEPTH));
        assign push[i]      = req_valid[i] && req_ready[i];
        assign pop[i]       = grant_valid && (grant_idx == IDX_W'(i));

        conv_arb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENT_W)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   ({req_last[i], req_sel[i*SEL_W +: SEL_W],
                     req_addr[i*ADDR_W +: ADDR_W], req_data[i*DATA_W +: DATA_W]}),
            .dout  (fifo_dout[i]),
            .count (fifo_count[i]),
            .empty (fifo_empty[i])
        );
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (&last_flag && &fifo_empty && !cwr) state_nxt = ST_DONE;
            ST_DONE: if (start) state_nxt = ST_RUN;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        run       = (state == ST_RUN);
        busy      = run;
        done      = (state == ST_DONE);
        start_acc = start && (state != ST_RUN);
    end

    // NOTE: defaults first so no path through the loop leaves a latch behind.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (run && !grant_valid && !fifo_empty[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(idx);
            end
        end
    end

    assign head = fifo_dout[grant_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= '0;
            cwr       <= 1'b0;
            caddr_wr  <= '0;
            cdata_wr  <= '0;
            csel      <= '0;
            last_flag <= '0;
        end else begin
            cwr <= grant_valid;
            if (grant_valid) begin
                rr_ptr   <= (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
                csel     <= head[ENT_W-2 -: SEL_W];
                caddr_wr <= head[DATA_W +: ADDR_W];
                cdata_wr <= head[DATA_W-1:0];
            end
            if (start_acc) last_flag <= '0;
            else if (grant_valid && head[ENT_W-1]) last_flag[grant_idx] <= 1'b1;
        end
    end

`ifdef CONV_ARB_STAT_EN
    logic [ADDR_W:0] cnt_q [N_REQ];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
        end else if (start) begin
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
        end else if (grant_valid && (cnt_q[grant_idx] != '1)) begin
            cnt_q[grant_idx] <= cnt_q[grant_idx] + (ADDR_W+1)'(1);
        end
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
        assign wr_cnt[i*(ADDR_W+1) +: ADDR_W+1] = cnt_q[i];
    end
`endif

endmodule
